vdma_frame_ptr_arbiter: RTL and testbench
=========================================

# vdma_frame_ptr_arbiter

Parametrised frame-buffer pointer arbiter for the VDMA: one writer (`mm_tras` side) and up to four independent readers (`mm_rev` side) share a ring of up to eight frame buffers in AXI memory. It generalises the fixed one-writer / three-reader base-address control to configurable buffer and reader counts. It adds reader locking, so the writer never overwrites a buffer being read, plus frame IDs and repeat/abort reporting. It sits in the pixel-clock domain beside the port and drives `wr_baseaddr` / `rd_baseaddr` directly.

## Interface
- `NUM_BUF`, 4, number of frame buffers, 2..8
- `NUM_RD`, 2, number of readers, 1..4; elaboration `$error` unless `NUM_BUF >= NUM_RD + 2`
- `ASIZE`, 29, AXI address width
- `FID_W`, 8, frame-ID counter width
- `BASE_ADDR_LIST`, 0, packed `8*ASIZE` vector; buffer k base = bits `[k*ASIZE +: ASIZE]`
- `clock`  in  1  sole clock; all logic is on the rising edge
- `rst`  in  1  asynchronous, active-high reset
- `wr_frame_start`  in  1  single-cycle pulse: the writer begins a frame
- `wr_frame_done`  in  1  single-cycle pulse: the writer's last burst is acknowledged
- `rd_frame_start`  in  NUM_RD  per-reader pulse: the reader begins a frame
- `rd_frame_done`  in  NUM_RD  per-reader pulse: the reader finishes a frame
- `wr_point`  out  3  buffer index owned by the writer
- `wr_baseaddr`  out  ASIZE  base of `wr_point`
- `wr_busy`  out  1  set from start to done/abort
- `wr_abort`  out  1  pulse: a frame was restarted before done
- `rd_point`  out  3*NUM_RD  buffer index per reader
- `rd_baseaddr`  out  ASIZE*NUM_RD  base per reader
- `rd_valid`  out  NUM_RD  reader holds a completed frame
- `rd_frame_id`  out  FID_W*NUM_RD  ID of the frame held
- `rd_repeat`  out  NUM_RD  pulse: the reader was re-served the same frame ID
- `lock_mask`  out  8  buffers currently locked by a reader (bits ≥ NUM_BUF are 0)

## Operation
- **State held:**
  - `latest` (3b) and `latest_valid`
  - `buf_fid[NUM_BUF]`
  - per reader: `rd_lock[i]` and `rd_point[i]`
  - `wr_busy`
  - `fid_cnt` (FID_W, wraps modulo 2^FID_W)
- **lock_mask:** OR over i of `rd_lock[i]` one-hot(`rd_point[i]`).
- **Writer select on `wr_frame_start`:**
  - Candidate set is `~(lock_mask | onehot(latest) & latest_valid)` over `0..NUM_BUF-1`.
  - Search round-robin, starting at `wr_point+1` mod NUM_BUF, and take the first candidate.
  - The parameter constraint guarantees at least one candidate.
  - Effects: `wr_busy`←1; `wr_point` and `wr_baseaddr` update.
- **Abort:** `wr_frame_start` while `wr_busy`=1 pulses `wr_abort`. The aborted frame is discarded (`latest` unchanged) and selection proceeds as above.
- **Writer completion, `wr_frame_done` with `wr_busy`=1:**
  - `latest`←`wr_point`, `latest_valid`←1
  - `buf_fid[wr_point]`←`fid_cnt`, `fid_cnt`++
  - `wr_busy`←0
- **Stray done:** `wr_frame_done` with `wr_busy`=0 is ignored.
- **Reader start, `rd_frame_start[i]`:**
  - If `latest_valid` (after a same-cycle bypass, see Timing): `rd_point[i]`←`latest`, `rd_lock[i]`←1, `rd_valid[i]`←1, `rd_frame_id[i]`←fid.
  - `rd_repeat[i]` pulses if the new fid equals the previous `rd_frame_id[i]` and `rd_valid[i]` was already 1.
  - If no frame is valid: `rd_valid[i]`=0, no lock, `rd_point[i]` unchanged.
  - A start while already locked implicitly releases the old lock.
- **Reader done:** `rd_frame_done[i]` clears `rd_lock[i]`. `rd_point`, `rd_valid` and `rd_frame_id` hold. Done without a lock is ignored.
- **Shared buffers:** several readers may lock the same buffer.

## Timing
- All outputs are registered.
- Latency is 1 cycle from any input pulse to the updated `wr_*`/`rd_*`/`lock_mask`.
- Pulses (`wr_abort`, `rd_repeat`) are exactly 1 cycle wide, asserted on the cycle after the triggering input.
- **Reset values:**
  - `wr_point`=0, `wr_baseaddr`=buffer-0 base, `wr_busy`=0, `wr_abort`=0
  - `rd_point`=0, `rd_baseaddr`=buffer-0 base, `rd_valid`=0, `rd_frame_id`=0, `rd_repeat`=0
  - `lock_mask`=0, `latest_valid`=0, `fid_cnt`=0
- **Reset mid-frame:** drops all locks and validity at once, with no pulses.
- **`wr_frame_done` and `rd_frame_start[i]` in the same cycle:** the reader is served the just-completed buffer and fid (bypass).
- **`wr_frame_start` and `rd_frame_start[i]` in the same cycle:** the writer's candidate set excludes `latest` whether `latest` comes from the registered value or from a same-cycle done. The reader and writer therefore never collide.
- **`wr_frame_start` and `wr_frame_done` in the same cycle:** the done is processed first (commit), then the new start selects, excluding the new `latest`. This is not an abort.
- **`rd_frame_done[i]` and `rd_frame_start[i]` in the same cycle:** treated as a start (re-lock).
- **Lock release versus selection:** a lock released by `rd_frame_done` in cycle t is not free for a writer selection in cycle t. It becomes available from t+1.

## Test plan
- **Basic ring:** NUM_BUF=4, NUM_RD=2, no readers; 5 write frames → `wr_point` sequence 0,1,2,3,… skipping `latest`; exact sequence 0,1,2,3,0; `rd_valid`=0.
- **Lock protection:**
  - Stimulus: reader 0 starts after frame 0 completes (locks buf 0); the writer runs 6 frames while reader 0 is held.
  - Required: `wr_point` is never 0; `lock_mask`=0x01.
  - After `rd_frame_done[0]`, `lock_mask`=0x00 and buf 0 becomes selectable again.
- **Bypass:** `wr_frame_done` (frame in buf 2, fid 7) in the same cycle as `rd_frame_start[1]` → next cycle `rd_point[1]`=2, `rd_frame_id[1]`=7, `rd_valid[1]`=1.
- **Repeat:** reader 0 starts twice with no intervening write done → second start pulses `rd_repeat[0]` with the same fid.
- **Abort:**
  - Stimulus: `wr_frame_start` twice without done.
  - Required: `wr_abort` pulses once; `latest` is unchanged; `fid_cnt` does not increment; the new `wr_point` is the next round-robin candidate.
- **Reset:** assert `rst` asynchronously mid-frame with locks held → all outputs reach their reset values without waiting for a clock edge; `lock_mask`=0.

Source files
------------

// File: rtl/vdma_frame_ptr_arbiter.sv
// VDMA frame-buffer pointer arbiter: one writer and NUM_RD readers share a
// ring of NUM_BUF buffers, with reader locks, frame IDs and abort/repeat pulses.
module vdma_frame_ptr_arbiter #(
  parameter int NUM_BUF = 4,
  parameter int NUM_RD = 2,
  parameter int ASIZE = 29,
  parameter int FID_W = 8,
  parameter logic [8*ASIZE-1:0] BASE_ADDR_LIST = '0
) (
  input  logic                    clock,
  input  logic                    rst,
  input  logic                    wr_frame_start,
  input  logic                    wr_frame_done,
  input  logic [NUM_RD-1:0]       rd_frame_start,
  input  logic [NUM_RD-1:0]       rd_frame_done,
  output logic [2:0]              wr_point,
  output logic [ASIZE-1:0]        wr_baseaddr,
  output logic                    wr_busy,
  output logic                    wr_abort,
  output logic [3*NUM_RD-1:0]     rd_point,
  output logic [ASIZE*NUM_RD-1:0] rd_baseaddr,
  output logic [NUM_RD-1:0]       rd_valid,
  output logic [FID_W*NUM_RD-1:0] rd_frame_id,
  output logic [NUM_RD-1:0]       rd_repeat,
  output logic [7:0]              lock_mask
);

  if (NUM_BUF < NUM_RD + 2 || NUM_BUF > 8 ||
      NUM_RD < 1 || NUM_RD > 4) begin : g_bad_cfg
    $error("vdma_frame_ptr_arbiter: need NUM_BUF >= NUM_RD + 2");
  end

  localparam logic [8:0] BUF_ALL9 = (9'd1 << NUM_BUF) - 9'd1;
  localparam logic [7:0] BUF_ALL = BUF_ALL9[7:0];

  function automatic logic [ASIZE-1:0] base_of(input logic [2:0] k);
    return BASE_ADDR_LIST[32'(k)*ASIZE +: ASIZE];
  endfunction

  logic [2:0]       latest;
  logic             latest_valid;
  logic             wr_init;
  logic [FID_W-1:0] fid_cnt;
  logic [FID_W-1:0] buf_fid [8];

  logic [2:0]       rp_q [NUM_RD];
  logic [ASIZE-1:0] rb_q [NUM_RD];
  logic [FID_W-1:0] rf_q [NUM_RD];
  logic [NUM_RD-1:0] lock_q;

  logic             commit;
  logic             eff_valid;
  logic [2:0]       eff_latest;
  logic [FID_W-1:0] eff_fid;
  logic [7:0]       excl;
  logic [7:0]       cand;
  logic [2:0]       start_idx;
  logic [2:0]       sel;
  logic             found;
  logic [3:0]       idx;

  logic [2:0]        rp_n [NUM_RD];
  logic [FID_W-1:0]  rf_n [NUM_RD];
  logic [NUM_RD-1:0] lk_n;
  logic [NUM_RD-1:0] rv_n;
  logic [NUM_RD-1:0] rep_n;
  logic [7:0]        mask_n;

  // A same-cycle commit is visible to readers and to the writer's search
  assign commit     = wr_frame_done & wr_busy;
  assign eff_valid  = commit | latest_valid;
  assign eff_latest = commit ? wr_point : latest;
  assign eff_fid    = commit ? fid_cnt : buf_fid[latest];

  always_comb begin
    excl = lock_mask;
    if (eff_valid) excl = excl | (8'd1 << eff_latest);
    cand = ~excl & BUF_ALL;
  end

  always_comb begin
    if (!wr_init) start_idx = '0;
    else if (wr_point == 3'(NUM_BUF - 1)) start_idx = '0;
    else start_idx = wr_point + 3'd1;
  end

  always_comb begin
    sel = start_idx;
    found = 1'b0;
    idx = '0;
    for (int k = 0; k < NUM_BUF; k++) begin
      idx = {1'b0, start_idx} + 4'(k);
      if (idx >= 4'(NUM_BUF)) idx = idx - 4'(NUM_BUF);
      if (!found && cand[idx[2:0]]) begin
        sel = idx[2:0];
        found = 1'b1;
      end
    end
  end

  always_comb begin
    lk_n = lock_q;
    rv_n = rd_valid;
    rep_n = '0;
    mask_n = '0;
    for (int i = 0; i < NUM_RD; i++) begin
      rp_n[i] = rp_q[i];
      rf_n[i] = rf_q[i];
      if (rd_frame_start[i]) begin
        lk_n[i] = eff_valid;
        rv_n[i] = eff_valid;
        if (eff_valid) begin
          rp_n[i] = eff_latest;
          rf_n[i] = eff_fid;
          rep_n[i] = rd_valid[i] && (rf_q[i] == eff_fid);
        end
      end else if (rd_frame_done[i]) begin
        lk_n[i] = 1'b0;
      end
      if (lk_n[i]) mask_n = mask_n | (8'd1 << rp_n[i]);
    end
  end

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      wr_point     <= '0;
      wr_baseaddr  <= base_of(3'd0);
      wr_busy      <= 1'b0;
      wr_abort     <= 1'b0;
      wr_init      <= 1'b0;
      latest       <= '0;
      latest_valid <= 1'b0;
      fid_cnt      <= '0;
      for (int k = 0; k < 8; k++) buf_fid[k] <= '0;
      for (int i = 0; i < NUM_RD; i++) begin
        rp_q[i] <= '0;
        rb_q[i] <= base_of(3'd0);
        rf_q[i] <= '0;
      end
      lock_q    <= '0;
      rd_valid  <= '0;
      rd_repeat <= '0;
      lock_mask <= '0;
    end else begin
      wr_abort <= wr_frame_start & wr_busy & ~wr_frame_done;
      if (commit) begin
        latest           <= wr_point;
        latest_valid     <= 1'b1;
        buf_fid[wr_point] <= fid_cnt;
        fid_cnt          <= fid_cnt + 1'b1;
      end
      if (wr_frame_start) begin
        wr_point    <= sel;
        wr_baseaddr <= base_of(sel);
        wr_busy     <= 1'b1;
        wr_init     <= 1'b1;
      end else if (commit) begin
        wr_busy <= 1'b0;
      end
      for (int i = 0; i < NUM_RD; i++) begin
        rp_q[i] <= rp_n[i];
        rb_q[i] <= base_of(rp_n[i]);
        rf_q[i] <= rf_n[i];
      end
      lock_q    <= lk_n;
      rd_valid  <= rv_n;
      rd_repeat <= rep_n;
      lock_mask <= mask_n;
    end
  end

  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd_out
    assign rd_point[3*i +: 3]         = rp_q[i];
    assign rd_baseaddr[ASIZE*i +: ASIZE] = rb_q[i];
    assign rd_frame_id[FID_W*i +: FID_W] = rf_q[i];
  end

endmodule

// File: tb/tb_vdma_frame_ptr_arbiter.sv
// Bench for vdma_frame_ptr_arbiter: table of per-cycle vectors checked
// through a cycle-stamped scoreboard, plus an asynchronous reset sequence.
module tb_vdma_frame_ptr_arbiter;

  localparam int AW = 29;

  function automatic logic [AW-1:0] base(input int k);
    return AW'((k + 1) << 20) | AW'(k * 'h40);
  endfunction

  function automatic logic [8*AW-1:0] mk_list();
    logic [8*AW-1:0] l;
    l = '0;
    for (int k = 0; k < 8; k++) l[k*AW +: AW] = base(k);
    return l;
  endfunction

  localparam logic [8*AW-1:0] BL = mk_list();

  logic clock;
  logic rst;
  logic wr_frame_start, wr_frame_done;
  logic [1:0] rd_frame_start, rd_frame_done;
  logic [2:0] wr_point;
  logic [AW-1:0] wr_baseaddr;
  logic wr_busy, wr_abort;
  logic [5:0] rd_point;
  logic [2*AW-1:0] rd_baseaddr;
  logic [1:0] rd_valid;
  logic [15:0] rd_frame_id;
  logic [1:0] rd_repeat;
  logic [7:0] lock_mask;

  vdma_frame_ptr_arbiter #(
    .NUM_BUF(4), .NUM_RD(2), .ASIZE(AW), .FID_W(8),
    .BASE_ADDR_LIST(BL)
  ) dut (
    .clock(clock), .rst(rst),
    .wr_frame_start(wr_frame_start), .wr_frame_done(wr_frame_done),
    .rd_frame_start(rd_frame_start), .rd_frame_done(rd_frame_done),
    .wr_point(wr_point), .wr_baseaddr(wr_baseaddr),
    .wr_busy(wr_busy), .wr_abort(wr_abort),
    .rd_point(rd_point), .rd_baseaddr(rd_baseaddr),
    .rd_valid(rd_valid), .rd_frame_id(rd_frame_id),
    .rd_repeat(rd_repeat), .lock_mask(lock_mask)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic ws, wd;
    logic [1:0] rs, rd;
    logic [2:0] wp;
    logic busy, ab;
    logic [2:0] rp0, rp1;
    logic [1:0] rv;
    logic [7:0] f0, f1;
    logic [1:0] rep;
    logic [7:0] lock;
  } vec_t;

  typedef struct {
    int due;
    int id;
    logic [127:0] exp;
  } sb_t;

  vec_t tv[$];
  sb_t sb[$];
  int cyc = 0;
  int nvec = 0;
  int nerr = 0;
  logic [127:0] act;

  assign act = 128'({wr_point, wr_baseaddr, wr_busy, wr_abort, rd_point,
                     rd_baseaddr, rd_valid, rd_frame_id, rd_repeat, lock_mask});

  function automatic vec_t mk(input int ws, wd, rs, rd, wp, busy, ab,
                              rp0, rp1, rv, f0, f1, rep, lock);
    vec_t v;
    v.ws = ws[0]; v.wd = wd[0]; v.rs = rs[1:0]; v.rd = rd[1:0];
    v.wp = wp[2:0]; v.busy = busy[0]; v.ab = ab[0];
    v.rp0 = rp0[2:0]; v.rp1 = rp1[2:0]; v.rv = rv[1:0];
    v.f0 = f0[7:0]; v.f1 = f1[7:0]; v.rep = rep[1:0]; v.lock = lock[7:0];
    return v;
  endfunction

  function automatic logic [127:0] pk(input vec_t v);
    return 128'({v.wp, base(int'(v.wp)), v.busy, v.ab, v.rp1, v.rp0,
                 base(int'(v.rp1)), base(int'(v.rp0)), v.rv, v.f1, v.f0,
                 v.rep, v.lock});
  endfunction

  always @(posedge clock) cyc <= cyc + 1;

  always @(negedge clock) begin
    sb_t e;
    while (sb.size() > 0 && sb[0].due <= cyc) begin
      e = sb.pop_front();
      nvec++;
      if (act !== e.exp) begin
        nerr++;
        $display("FAIL vec%0d: got %h want %h", e.id, act, e.exp);
      end
    end
  end

  task automatic apply(input vec_t v, input int id);
    sb_t e;
    @(negedge clock);
    wr_frame_start = v.ws;
    wr_frame_done = v.wd;
    rd_frame_start = v.rs;
    rd_frame_done = v.rd;
    e.due = cyc + 1;
    e.id = id;
    e.exp = pk(v);
    sb.push_back(e);
  endtask

  task automatic idle();
    @(negedge clock);
    wr_frame_start = 1'b0;
    wr_frame_done = 1'b0;
    rd_frame_start = '0;
    rd_frame_done = '0;
  endtask

  initial begin
    rst = 1'b1;
    wr_frame_start = 1'b0;
    wr_frame_done = 1'b0;
    rd_frame_start = '0;
    rd_frame_done = '0;

    // ring with no readers: 0,1,2,3,0
    tv.push_back(mk(0,0,0,0, 0,0,0, 0,0,0,0,0,0,0));
    tv.push_back(mk(1,0,0,0, 0,1,0, 0,0,0,0,0,0,0));
    tv.push_back(mk(0,1,0,0, 0,0,0, 0,0,0,0,0,0,0));
    tv.push_back(mk(1,0,0,0, 1,1,0, 0,0,0,0,0,0,0));
    tv.push_back(mk(0,1,0,0, 1,0,0, 0,0,0,0,0,0,0));
    tv.push_back(mk(1,0,0,0, 2,1,0, 0,0,0,0,0,0,0));
    tv.push_back(mk(0,1,0,0, 2,0,0, 0,0,0,0,0,0,0));
    tv.push_back(mk(1,0,0,0, 3,1,0, 0,0,0,0,0,0,0));
    tv.push_back(mk(0,1,0,0, 3,0,0, 0,0,0,0,0,0,0));
    tv.push_back(mk(1,0,0,0, 0,1,0, 0,0,0,0,0,0,0));
    tv.push_back(mk(0,1,0,0, 0,0,0, 0,0,0,0,0,0,0));
    // reader 0 holds buf 0 while six frames are written
    tv.push_back(mk(0,0,1,0, 0,0,0, 0,0,1,4,0,0,1));
    tv.push_back(mk(1,0,0,0, 1,1,0, 0,0,1,4,0,0,1));
    tv.push_back(mk(0,1,0,0, 1,0,0, 0,0,1,4,0,0,1));
    tv.push_back(mk(1,0,0,0, 2,1,0, 0,0,1,4,0,0,1));
    tv.push_back(mk(0,1,0,0, 2,0,0, 0,0,1,4,0,0,1));
    tv.push_back(mk(1,0,0,0, 3,1,0, 0,0,1,4,0,0,1));
    tv.push_back(mk(0,1,0,0, 3,0,0, 0,0,1,4,0,0,1));
    tv.push_back(mk(1,0,0,0, 1,1,0, 0,0,1,4,0,0,1));
    tv.push_back(mk(0,1,0,0, 1,0,0, 0,0,1,4,0,0,1));
    tv.push_back(mk(1,0,0,0, 2,1,0, 0,0,1,4,0,0,1));
    tv.push_back(mk(0,1,0,0, 2,0,0, 0,0,1,4,0,0,1));
    tv.push_back(mk(1,0,0,0, 3,1,0, 0,0,1,4,0,0,1));
    tv.push_back(mk(0,1,0,0, 3,0,0, 0,0,1,4,0,0,1));
    // release in the same cycle as a start: buf 0 still skipped
    tv.push_back(mk(1,0,0,1, 1,1,0, 0,0,1,4,0,0,0));
    tv.push_back(mk(0,1,0,0, 1,0,0, 0,0,1,4,0,0,0));
    tv.push_back(mk(1,0,0,0, 2,1,0, 0,0,1,4,0,0,0));
    tv.push_back(mk(0,1,0,0, 2,0,0, 0,0,1,4,0,0,0));
    tv.push_back(mk(1,0,0,0, 3,1,0, 0,0,1,4,0,0,0));
    tv.push_back(mk(0,1,0,0, 3,0,0, 0,0,1,4,0,0,0));
    tv.push_back(mk(1,0,0,0, 0,1,0, 0,0,1,4,0,0,0));
    tv.push_back(mk(0,1,0,0, 0,0,0, 0,0,1,4,0,0,0));
    // repeat on reader 0
    tv.push_back(mk(0,0,1,0, 0,0,0, 0,0,1,14,0,0,1));
    tv.push_back(mk(0,0,1,0, 0,0,0, 0,0,1,14,0,1,1));
    tv.push_back(mk(0,0,0,1, 0,0,0, 0,0,1,14,0,0,0));
    // bypass: done and reader 1 start together
    tv.push_back(mk(1,0,0,0, 1,1,0, 0,0,1,14,0,0,0));
    tv.push_back(mk(0,1,0,0, 1,0,0, 0,0,1,14,0,0,0));
    tv.push_back(mk(1,0,0,0, 2,1,0, 0,0,1,14,0,0,0));
    tv.push_back(mk(0,1,2,0, 2,0,0, 0,2,3,14,16,0,4));
    // start+done+reader start together, then abort
    tv.push_back(mk(1,0,0,0, 3,1,0, 0,2,3,14,16,0,4));
    tv.push_back(mk(1,1,1,0, 0,1,0, 3,2,3,17,16,0,12));
    tv.push_back(mk(1,0,0,0, 1,1,1, 3,2,3,17,16,0,12));
    tv.push_back(mk(0,1,0,0, 1,0,0, 3,2,3,17,16,0,12));
    // done+start on same reader is a re-lock; shared buffer
    tv.push_back(mk(0,0,3,3, 1,0,0, 1,1,3,18,18,0,2));
    tv.push_back(mk(0,0,1,0, 1,0,0, 1,1,3,18,18,1,2));
    tv.push_back(mk(0,1,0,0, 1,0,0, 1,1,3,18,18,0,2));
    tv.push_back(mk(0,0,0,3, 1,0,0, 1,1,3,18,18,0,0));
    tv.push_back(mk(0,0,1,0, 1,0,0, 1,1,3,18,18,1,2));
    tv.push_back(mk(1,0,0,0, 2,1,0, 1,1,3,18,18,0,2));
    // after reset: no valid frame, ring restarts at 0
    tv.push_back(mk(0,0,1,0, 0,0,0, 0,0,0,0,0,0,0));
    tv.push_back(mk(1,0,0,0, 0,1,0, 0,0,0,0,0,0,0));
    tv.push_back(mk(0,1,2,0, 0,0,0, 0,0,2,0,0,0,1));

    repeat (3) @(negedge clock);
    rst = 1'b0;

    for (int i = 0; i < 49; i++) apply(tv[i], i);
    idle();

    // asynchronous reset between clock edges, mid-frame with a lock held
    #2 rst = 1'b1;
    #1;
    nvec++;
    if (act !== pk(mk(0,0,0,0, 0,0,0, 0,0,0,0,0,0,0))) begin
      nerr++;
      $display("FAIL async_rst: got %h want %h", act,
               pk(mk(0,0,0,0, 0,0,0, 0,0,0,0,0,0,0)));
    end
    #1 rst = 1'b0;

    for (int i = 49; i < tv.size(); i++) apply(tv[i], i);
    idle();
    repeat (3) @(negedge clock);
    if (sb.size() != 0) begin
      nerr++;
      $display("FAIL drain: got %0d pending want 0", sb.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
